breath_led_axi_multi: RTL and testbench
=======================================

// Module: breath_led_axi_multi
// PURPOSE
// - NUM_CH-channel breathing-LED PWM controller with an AXI4-Lite slave register file.
// - Parametrised successor of the single-channel breath LED AXI IP.
// - Adds per-channel enable, per-channel peak duty, a shared ramp prescaler and a direction status.
// - Sits on a PS/MicroBlaze AXI interconnect; led_o drives board LEDs directly.
// PARAMETERS
// - NUM_CH             4   LED channels, 1..8
// - PWM_W              8   PWM counter / duty width in bits, 4..16
// - C_S_AXI_DATA_WIDTH 32  AXI data width; fixed at 32
// - C_S_AXI_ADDR_WIDTH 6   byte address width; map spans 0x00..0x2F
// PORTS
// - s00_axi_aclk     in   1         single clock for all logic
// - s00_axi_areset   in   1         asynchronous, active-high reset
// - s00_axi_aw*      in/out         awaddr[ADDR_W], awprot[3], awvalid, awready
// - s00_axi_w*       in/out         wdata[32], wstrb[4], wvalid, wready
// - s00_axi_b*       in/out         bresp[2], bvalid, bready
// - s00_axi_ar*      in/out         araddr[ADDR_W], arprot[3], arvalid, arready
// - s00_axi_r*       in/out         rdata[32], rresp[2], rvalid, rready
// - led_o            out  NUM_CH    PWM output per channel, active-high
// BEHAVIOUR
// - Register map:
//   - 0x00 CTRL      RW  [NUM_CH-1:0] channel enable
//   - 0x04 STATUS    RO  [NUM_CH-1:0] ramp direction, 1=down; [16+NUM_CH-1:16] duty==0 flags
//   - 0x08 PRESCALE  RW  [23:0] cycles per duty step minus 1
//   - 0x10+4*i PEAK  RW  [PWM_W-1:0] peak duty for channel i
// - Reset values:
//   - Registers: CTRL=0, PRESCALE=0x00FFFF, PEAK=all ones.
//   - Outputs: all READY/VALID=0, bresp=rresp=0, rdata=0, led_o=0.
//   - Internals: duty=0, dir=up, all counters=0.
// - Write channel:
//   - awready and wready pulse together for 1 cycle when awvalid&wvalid&!bvalid.
//   - Register updates on that cycle, byte-wise per wstrb.
//   - bvalid rises the next cycle and holds until bready.
//   - AW or W arriving alone waits; no response is issued for it.
// - Read channel:
//   - arready pulses 1 cycle when arvalid&!rvalid.
//   - rdata/rvalid valid the next cycle, held until rready.
//   - At most one read outstanding.
// - Responses always OKAY. Unmapped reads return 0; unmapped or RO writes are ignored but still get bvalid.
// - Prescaler: counts 0..PRESCALE; tick=1 for one cycle at terminal count, then wraps to 0.
//   - A PRESCALE write restarts the counter at 0.
// - PWM counter: free-running 0..2^PWM_W-1, wraps.
//   - Combinational output led_o[i] = en[i] & (pwm_cnt < cmp[i]); cmp = duty, or gamma value (below).
// - Per-channel ramp (states UP/DOWN), applied on tick only:
//   - UP: duty+1. When duty+1 >= PEAK, load duty=PEAK and go DOWN.
//   - DOWN: duty-1. When duty reaches 0, go UP.
//   - PEAK=0: duty stays 0, state stays UP, led_o stays 0.
//   - PEAK lowered below the current duty: next tick loads duty=PEAK and goes DOWN.
// - Disable (en[i]=0): duty=0, dir=UP immediately; led_o[i]=0 the next cycle.
// - Re-enable: ramp restarts from 0.
// - Reset asserted mid-transaction: all state returns to reset values and any pending bvalid/rvalid is dropped.
// CONFIGURATION
// - BREATH_GAMMA_EN defined: cmp[i] = (duty*duty) >> PWM_W.
//   - Registered; adds 1 cycle of latency from duty to led_o.
//   - Gives a perceptually linear fade.
// - BREATH_GAMMA_EN undefined: cmp[i] = duty, linear, no extra register.
// - The register map is identical in both builds.
// TESTING
// - Reset check: read 0x00/0x08/0x10 -> 0x0, 0x00FFFF, 0xFF. led_o=0.
// - Write/read back:
//   - Write 0x10..0x1C = 0x11,0x22,0x33,0x44 -> reads return the same values, bresp=rresp=0.
//   - Write 0x10=0xAABBCCDD with wstrb=4'b0001 -> PEAK0 reads 0xDD.
// - Ramp: PRESCALE=0, PEAK0=4, CTRL=1 -> duty0 on successive ticks 1,2,3,4,3,2,1,0,1; STATUS[0]=1 while descending.
// - PWM duty: hold duty0=64 (PEAK0=64, PRESCALE=0xFFFFFF) -> led_o[0] high 64 of every 256 cycles.
//   - With BREATH_GAMMA_EN: high 16 of every 256 cycles.
// - Handshake stress:
//   - AW 5 cycles before W, bready held low 10 cycles -> exactly one write, bvalid held 10 cycles.
//   - Read of 0x24 -> rdata=0.
// - Reset mid-ramp: assert s00_axi_areset with bvalid pending -> bvalid=0 and led_o=0 that cycle; CTRL reads 0 after release.

Source files
------------

// File: rtl/breath_led_axi_multi.sv
// NUM_CH-channel breathing-LED PWM controller behind an AXI4-Lite register file.
// Build macro BREATH_GAMMA_EN enables a registered squared-duty (gamma) compare stage.
module breath_led_axi_multi #(
    parameter int NUM_CH             = 4,
    parameter int PWM_W              = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [NUM_CH-1:0]               led_o
);

    localparam int DATA_W    = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
    localparam int IDX_PEAK0 = 4;
    localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_PRESCALE = IDX_W'(2);

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic [23:0]       prescale;
    logic [23:0]       pre_cnt;
    logic              tick;
    logic              pre_wr;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [PWM_W-1:0]  peak     [NUM_CH];
    logic [PWM_W-1:0]  duty     [NUM_CH];
    logic [PWM_W-1:0]  duty_nxt [NUM_CH];
    logic [PWM_W-1:0]  cmp      [NUM_CH];
    dir_t              dir      [NUM_CH];
    dir_t              dir_nxt  [NUM_CH];

    logic              wr_fire;
    logic              rd_fire;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;
    logic              unused_bits;

    assign clk     = s00_axi_aclk;
    assign rst     = s00_axi_areset;
    assign wr_fire = s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_fire = s00_axi_arready & s00_axi_arvalid;
    assign wr_idx  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx  = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                           s00_axi_araddr[1:0], wr_word[DATA_W-1:24]};

    function automatic logic [DATA_W-1:0] reg_word(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] w;
        w = '0;
        if (idx == IDX_CTRL) begin
            w[NUM_CH-1:0] = en;
        end else if (idx == IDX_STATUS) begin
            for (int i = 0; i < NUM_CH; i++) begin
                w[i]      = (dir[i] == DOWN);
                w[16 + i] = (duty[i] == '0);
            end
        end else if (idx == IDX_PRESCALE) begin
            w[23:0] = prescale;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (idx == IDX_W'(IDX_PEAK0 + i)) w[PWM_W-1:0] = peak[i];
        end
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] merge_strb(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [DATA_W/8-1:0] strb);
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int b = 0; b < DATA_W / 8; b++)
            if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
        return m;
    endfunction

    always_comb begin
        wr_old  = reg_word(wr_idx);
        wr_word = merge_strb(wr_old, s00_axi_wdata, s00_axi_wstrb);
        rd_word = reg_word(rd_idx);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            // AW and W are accepted together only; a lone AW or W just waits.
            s00_axi_awready <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
            s00_axi_wready  <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
            if (wr_fire)
                s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bready)
                s00_axi_bvalid <= 1'b0;
            s00_axi_arready <= s00_axi_arvalid & ~s00_axi_rvalid & ~s00_axi_arready;
            if (rd_fire) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_word;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    // NOTE: the PEAK array is a small set of control registers with a defined reset value, so it is reset like any flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en       <= '0;
            prescale <= 24'h00FFFF;
            for (int i = 0; i < NUM_CH; i++) peak[i] <= '1;
        end else if (wr_fire) begin
            if (wr_idx == IDX_CTRL)     en       <= wr_word[NUM_CH-1:0];
            if (wr_idx == IDX_PRESCALE) prescale <= wr_word[23:0];
            for (int i = 0; i < NUM_CH; i++)
                if (wr_idx == IDX_W'(IDX_PEAK0 + i)) peak[i] <= wr_word[PWM_W-1:0];
        end
    end

    assign pre_wr = wr_fire & (wr_idx == IDX_PRESCALE);
    assign tick   = (pre_cnt == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= (pre_wr || tick) ? 24'd0 : pre_cnt + 24'd1;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // NOTE: defaults first on every path keep this block free of inferred latches.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty_nxt[i] = duty[i];
            dir_nxt[i]  = dir[i];
            if (!en[i] || (tick && peak[i] == '0)) begin
                duty_nxt[i] = '0;
                dir_nxt[i]  = UP;
            end else if (tick) begin
                if (dir[i] == UP) begin
                    if (duty[i] >= peak[i] - 1'b1) begin
                        duty_nxt[i] = peak[i];
                        dir_nxt[i]  = DOWN;
                    end else begin
                        duty_nxt[i] = duty[i] + 1'b1;
                    end
                end else if (duty[i] > peak[i]) begin
                    duty_nxt[i] = peak[i];
                end else if (duty[i] <= PWM_W'(1)) begin
                    duty_nxt[i] = '0;
                    dir_nxt[i]  = UP;
                end else begin
                    duty_nxt[i] = duty[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty[i] <= '0;
                dir[i]  <= UP;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty[i] <= duty_nxt[i];
                dir[i]  <= dir_nxt[i];
            end
        end
    end

`ifdef BREATH_GAMMA_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) cmp[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                cmp[i] <= PWM_W'(({{PWM_W{1'b0}}, duty[i]} * {{PWM_W{1'b0}}, duty[i]}) >> PWM_W);
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) cmp[i] = duty[i];
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) led_o[i] = en[i] & (pwm_cnt < cmp[i]);
    end

endmodule

// File: tb/tb_breath_led_axi_multi.sv
// Directed self-checking bench for breath_led_axi_multi (NUM_CH=4, PWM_W=8).
module tb_breath_led_axi_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [5:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  led_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic [1:0]  resp;
    logic [7:0]  duty_s [32];
    logic        dir_s  [32];
    logic [7:0]  ramp_exp [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
    logic        ramp_dir [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int          k0;
    int          hi_cnt;
    int          other_cnt;
    int          aw_cnt;
    int          b_cnt;
    int          pwm_exp;
    logic        seen;

    breath_led_axi_multi #(
        .NUM_CH(4), .PWM_W(8), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awprot (awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arprot (arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .led_o          (led_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] r);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (awready && wready) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        if (!ok) check("write_accept_timeout", 32'd0, 32'd1);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bvalid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check("write_resp_timeout", 32'd0, 32'd1);
        r = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] r);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        arvalid = 1'b0;
        if (!ok) check("read_accept_timeout", 32'd0, 32'd1);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (rvalid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check("read_data_timeout", 32'd0, 32'd1);
        data = rdata; r = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
`ifdef BREATH_GAMMA_EN
        pwm_exp = 16;
`else
        pwm_exp = 64;
`endif
        repeat (3) @(negedge clk);
        check("rst_led", 32'(led_o), 32'h0);
        check("rst_bvalid_rvalid", {30'd0, bvalid, rvalid}, 32'h0);
        rst = 1'b0;

        axi_read(6'h00, rd, resp); check("rst_ctrl", rd, 32'h0);
        axi_read(6'h08, rd, resp); check("rst_prescale", rd, 32'h00FFFF);
        axi_read(6'h10, rd, resp); check("rst_peak0", rd, 32'hFF);

        // Peak registers write/read-back with OKAY responses.
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(6'h10 + 4 * i), 32'(8'h11 * (i + 1)), 4'hF, resp);
            check($sformatf("peak%0d_bresp", i), 32'(resp), 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(6'h10 + 4 * i), rd, resp);
            check($sformatf("peak%0d_rd", i), rd, 32'(8'h11 * (i + 1)));
            check($sformatf("peak%0d_rresp", i), 32'(resp), 32'h0);
        end

        axi_write(6'h10, 32'hAABBCCDD, 4'b0001, resp);
        axi_read(6'h10, rd, resp); check("peak0_strb", rd, 32'hDD);

        axi_write(6'h04, 32'hFFFFFFFF, 4'hF, resp);
        check("ro_write_bresp", 32'(resp), 32'h0);
        axi_read(6'h04, rd, resp); check("status_idle", rd, 32'h000F0000);
        axi_read(6'h24, rd, resp); check("unmapped_0x24", rd, 32'h0);
        axi_read(6'h0C, rd, resp); check("unmapped_0x0c", rd, 32'h0);

        // Ramp with a tick every cycle: capture duty0/dir0 around the enable.
        axi_write(6'h10, 32'h4, 4'hF, resp);
        axi_write(6'h08, 32'h0, 4'hF, resp);
        fork
            axi_write(6'h00, 32'h1, 4'hF, resp);
            for (int k = 0; k < 32; k++) begin
                @(negedge clk);
                duty_s[k] = dut.duty[0];
                dir_s[k]  = dut.dir[0];
            end
        join
        k0 = -1;
        for (int k = 0; k < 32; k++) if (k0 < 0 && duty_s[k] != 8'd0) k0 = k;
        if (k0 < 0 || k0 > 32 - 9) begin
            check("ramp_start", 32'd0, 32'd1);
        end else begin
            for (int j = 0; j < 9; j++) begin
                check($sformatf("ramp_duty%0d", j), 32'(duty_s[k0 + j]), 32'(ramp_exp[j]));
                check($sformatf("ramp_dir%0d", j), 32'(dir_s[k0 + j]), 32'(ramp_dir[j]));
            end
        end

        // Freeze channel 0 mid-rise, then step it once onto a lowered peak of 64.
        axi_write(6'h00, 32'h0, 4'hF, resp);
        axi_write(6'h10, 32'hFF, 4'hF, resp);
        axi_write(6'h14, 32'h0, 4'hF, resp);
        axi_write(6'h08, 32'h0, 4'hF, resp);
        axi_write(6'h00, 32'h3, 4'hF, resp);
        repeat (150) @(negedge clk);
        axi_write(6'h08, 32'hFFFFFF, 4'hF, resp);
        axi_read(6'h04, rd, resp); check("status_rising", rd, 32'h000E0000);
        axi_write(6'h10, 32'h40, 4'hF, resp);
        axi_write(6'h08, 32'd50, 4'hF, resp);
        repeat (70) @(negedge clk);
        axi_write(6'h08, 32'hFFFFFF, 4'hF, resp);
        axi_read(6'h04, rd, resp); check("status_peak_lowered", rd, 32'h000E0001);
        axi_read(6'h08, rd, resp); check("prescale_rd", rd, 32'hFFFFFF);

        hi_cnt = 0; other_cnt = 0;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            if (led_o[0]) hi_cnt++;
            if (led_o[3:1] != 3'b000) other_cnt++;
        end
        check("pwm_high_count", 32'(hi_cnt), 32'(pwm_exp));
        check("pwm_other_leds", 32'(other_cnt), 32'h0);

        // AW leads W by 5 cycles, bready held low for 10 cycles.
        aw_cnt = 0; seen = 1'b0;
        @(negedge clk);
        awaddr = 6'h14; wdata = 32'h5A; wstrb = 4'hF; awvalid = 1'b1;
        repeat (5) begin @(negedge clk); if (awready) aw_cnt++; end
        wvalid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (awready) begin aw_cnt++; seen = 1'b1; break; end
        end
        if (!seen) check("stress_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        b_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (bvalid) b_cnt++;
            if (awready) aw_cnt++;
            @(negedge clk);
        end
        check("stress_bvalid_hold", 32'(b_cnt), 32'd10);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("stress_bvalid_drop", 32'(bvalid), 32'h0);
        check("stress_one_accept", 32'(aw_cnt), 32'd1);
        axi_read(6'h14, rd, resp); check("stress_peak1", rd, 32'h5A);

        // Reset while a write response is pending and channel 0 is lit.
        @(negedge clk);
        awaddr = 6'h18; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (awready) begin seen = 1'b1; break; end
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        if (!seen) check("rst_mid_accept_timeout", 32'd0, 32'd1);
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (led_o[0]) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("rst_mid_led_lit", 32'(seen), 32'h1);
        check("rst_mid_bvalid_pending", 32'(bvalid), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_mid_bvalid", 32'(bvalid), 32'h0);
        check("rst_mid_led", 32'(led_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        axi_read(6'h00, rd, resp); check("rst_mid_ctrl", rd, 32'h0);
        axi_read(6'h18, rd, resp); check("rst_mid_peak2", rd, 32'hFF);

        // Disable mid-ramp clears duty and output at once.
        axi_write(6'h08, 32'h0, 4'hF, resp);
        axi_write(6'h00, 32'h1, 4'hF, resp);
        repeat (40) @(negedge clk);
        axi_read(6'h04, rd, resp); check("status_ramping", rd, 32'h000E0000);
        axi_write(6'h00, 32'h0, 4'hF, resp);
        check("disable_led", 32'(led_o), 32'h0);
        axi_read(6'h04, rd, resp); check("disable_status", rd, 32'h000F0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
